// File: rtl/fetch_stage_if.sv
// Instruction-memory and decode handshake bundle seen by the fetch stage.
// Signal suffixes are from the fetch stage's point of view.
interface fetch_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;
    logic            instr_valid_o;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_ready_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output instr_valid_o, instr_o, instr_pc_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  instr_valid_o, instr_o, instr_pc_o,
        output instr_ready_i
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited imem reads, in-order PC tag queue,
// instruction FIFO towards decode, and discard of stale responses after a flush.
module fetch_stage #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned XLEN       = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            incr_pc_o,
    fetch_stage_if.master   bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [CW-1:0]   r_outs;
    logic [CW-1:0]   r_discard;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_tag_wptr;
    logic [PW-1:0]   r_tag_rptr;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [XLEN-1:0] r_tag       [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_instr[FIFO_DEPTH];

    logic w_credit;
    logic w_req;
    logic w_accept;
    logic w_rsp;
    logic w_push;
    logic w_valid;
    logic w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Outstanding reads plus buffered entries never exceed the FIFO, so no response is lost.
    assign w_credit = (SW'(r_outs) + SW'(r_cnt)) < SW'(FIFO_DEPTH);
    assign w_req    = rst_n_i & ~stall_i & ~flush_i & w_credit;
    assign w_accept = w_req & bus.imem_gnt_i;
    assign w_rsp    = bus.imem_rvalid_i;
    assign w_push   = w_rsp & ~flush_i & (r_discard == '0);
    assign w_valid  = (r_cnt != '0) & ~flush_i;
    assign w_pop    = w_valid & bus.instr_ready_i;

    assign incr_pc_o         = w_accept;
    assign bus.imem_req_o    = w_req;
    assign bus.imem_addr_o   = rst_n_i ? pc_i : '0;
    assign bus.instr_valid_o = w_valid;
    assign bus.instr_o       = r_fifo_instr[r_rptr];
    assign bus.instr_pc_o    = r_fifo_pc[r_rptr];

    // In-flight and to-be-discarded response counters
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_outs    <= '0;
            r_discard <= '0;
        end else begin
            r_outs <= r_outs + CW'(w_accept) - CW'(w_rsp);
            if (flush_i) begin
                r_discard <= r_outs - CW'(w_rsp);
            end else if (w_rsp && (r_discard != '0)) begin
                r_discard <= r_discard - CW'(1);
            end
        end
    end

    // PC tags of issued reads, popped in order as responses return
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tag_wptr <= '0;
            r_tag_rptr <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) r_tag[i] <= '0;
        end else begin
            if (w_accept) begin
                r_tag[r_tag_wptr] <= pc_i;
                r_tag_wptr        <= ptr_inc(r_tag_wptr);
            end
            if (w_rsp) r_tag_rptr <= ptr_inc(r_tag_rptr);
        end
    end

    // Instruction FIFO towards decode; emptied by a flush
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo_pc[i]    <= '0;
                r_fifo_instr[i] <= '0;
            end
        end else if (flush_i) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wptr]    <= r_tag[r_tag_rptr];
                r_fifo_instr[r_wptr] <= bus.imem_rdata_i;
                r_wptr               <= ptr_inc(r_wptr);
            end
            if (w_pop) r_rptr <= ptr_inc(r_rptr);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    a_counters: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (r_discard <= r_outs) && (r_outs <= CW'(FIFO_DEPTH)));
    a_rvalid_outs: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        bus.imem_rvalid_i |-> (r_outs != '0));
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: PC block, memory and decode models around the DUT,
// checked against an in-order expected instruction stream.
module tb_fetch_stage;
    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        int unsigned ep;
    } mem_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        flush_i;
    logic        incr_pc_o;

    fetch_stage_if #(.XLEN(32)) bus ();

    fetch_stage #(.FIFO_DEPTH(DEPTH), .XLEN(32)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .pc_i      (pc_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .incr_pc_o (incr_pc_o),
        .bus       (bus)
    );

    always #5 clk_i = ~clk_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned epoch   = 0;
    int          buffered = 0;
    int          n_acc   = 0;
    int          n_pop   = 0;
    logic [31:0] pc;
    logic [31:0] exp_pc;
    logic [31:0] flush_tgt;
    logic [31:0] last_acc_addr;
    logic [31:0] last_pop_pc;
    mem_t        memq[$];

    int unsigned gnt_pct, lat_min, lat_max, rdy_pct;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic knobs(input int unsigned g, input int unsigned lmin,
                         input int unsigned lmax, input int unsigned r);
        gnt_pct = g; lat_min = lmin; lat_max = lmax; rdy_pct = r;
    endtask

    // One clock cycle: called at a negedge, drives inputs, checks, advances models.
    task automatic step();
        logic rv, acc, pop, exp_req, exp_valid;
        pc_i = pc;
        bus.imem_gnt_i = ($urandom_range(99) < gnt_pct);
        rv = (memq.size() != 0) && (memq[0].due <= cyc);
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rv ? memf(memq[0].addr) : 32'($urandom);
        bus.instr_ready_i = ($urandom_range(99) < rdy_pct);
        #1;
        exp_req = !stall_i && !flush_i && ((memq.size() + buffered) < int'(DEPTH));
        chk("req", 32'(bus.imem_req_o), 32'(exp_req));
        if (exp_req) chk("addr", bus.imem_addr_o, pc);
        acc = bus.imem_req_o & bus.imem_gnt_i;
        chk("incr", 32'(incr_pc_o), 32'(acc));
        exp_valid = (buffered != 0) && !flush_i;
        chk("valid", 32'(bus.instr_valid_o), 32'(exp_valid));
        pop = bus.instr_valid_o & bus.instr_ready_i;
        if (pop) begin
            chk("instr_pc", bus.instr_pc_o, exp_pc);
            chk("instr", bus.instr_o, memf(exp_pc));
            last_pop_pc = bus.instr_pc_o;
            exp_pc = exp_pc + 32'd4;
            n_pop++;
            buffered--;
        end
        if (rv) begin
            if (memq[0].ep == epoch && !flush_i) buffered++;
            void'(memq.pop_front());
        end
        if (acc) begin
            memq.push_back('{addr: pc, due: cyc + $urandom_range(lat_max, lat_min), ep: epoch});
            last_acc_addr = bus.imem_addr_o;
            n_acc++;
        end
        if (flush_i) begin
            epoch++;
            buffered = 0;
            exp_pc = flush_tgt;
            pc = flush_tgt;
        end else if (acc) begin
            pc = pc + 32'd4;
        end
        @(negedge clk_i);
        cyc++;
    endtask

    // Asynchronous reset at a negedge; outputs must clear immediately.
    task automatic do_reset(input logic [31:0] tgt);
        rst_n_i = 1'b0;
        bus.imem_gnt_i    = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.instr_ready_i = 1'b1;
        #1;
        chk("rst_req", 32'(bus.imem_req_o), 32'd0);
        chk("rst_addr", bus.imem_addr_o, 32'd0);
        chk("rst_incr", 32'(incr_pc_o), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("rst_instr", bus.instr_o, 32'd0);
        chk("rst_ipc", bus.instr_pc_o, 32'd0);
        repeat (2) @(negedge clk_i);
        memq.delete();
        buffered = 0;
        epoch++;
        pc = tgt;
        exp_pc = tgt;
        pc_i = tgt;
        stall_i = 1'b0;
        flush_i = 1'b0;
        rst_n_i = 1'b1;
    endtask

    initial begin
        int n0;
        bit found;
        pc = '0; exp_pc = '0; flush_tgt = '0; last_acc_addr = '0; last_pop_pc = '0;
        pc_i = '0; stall_i = 1'b0; flush_i = 1'b0;
        bus.imem_rdata_i = '0;
        knobs(100, 1, 1, 100);
        do_reset(32'h0);

        // Back-to-back stream at minimum latency
        n0 = n_pop;
        repeat (20) step();
        chk("stream_pops", 32'(n_pop - n0 >= 10), 32'd1);

        // Decode not ready: fetch stops after DEPTH accepts, head stays at pc 0
        do_reset(32'h0);
        knobs(100, 1, 1, 0);
        n0 = n_acc;
        repeat (8) step();
        chk("rdy0_accepts", 32'(n_acc - n0), 32'(DEPTH));
        chk("rdy0_head", bus.instr_pc_o, 32'h0);
        knobs(100, 1, 1, 100);
        repeat (10) step();

        // Flush with two reads in flight
        do_reset(32'h10);
        knobs(100, 4, 4, 100);
        repeat (2) step();
        flush_tgt = 32'h100; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        n0 = n_pop;
        for (int i = 0; i < 20 && n_pop == n0; i++) step();
        chk("flush_first_seen", 32'(n_pop != n0), 32'd1);
        chk("flush_first_pc", last_pop_pc, 32'h100);

        // Flush coinciding with a response while one entry is buffered
        do_reset(32'h200);
        knobs(100, 2, 2, 0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (buffered == 1 && memq.size() != 0 && memq[0].due <= cyc) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("flrv_setup", 32'(found), 32'd1);
        flush_tgt = 32'h300; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flrv_empty", 32'(bus.instr_valid_o), 32'd0);
        knobs(100, 1, 3, 100);
        repeat (15) step();

        // Stall while an ungranted request is pending
        do_reset(32'h400);
        knobs(0, 1, 1, 100);
        repeat (2) step();
        stall_i = 1'b1;
        n0 = n_acc;
        repeat (5) step();
        stall_i = 1'b0;
        chk("stall_noacc", 32'(n_acc - n0), 32'd0);
        knobs(100, 1, 1, 100);
        step();
        chk("stall_resume_addr", last_acc_addr, 32'h400);

        // Reset with two reads in flight
        knobs(100, 3, 3, 100);
        repeat (3) step();
        do_reset(32'h800);
        n0 = n_acc;
        step();
        chk("rst_resume_acc", 32'(n_acc - n0), 32'd1);
        chk("rst_resume_addr", last_acc_addr, 32'h800);

        // Randomised traffic with stalls, flushes and one reset
        do_reset(32'h1000);
        for (int blk = 0; blk < 30; blk++) begin
            knobs($urandom_range(100, 30), 1, $urandom_range(4, 1), $urandom_range(100, 20));
            if (blk == 15) do_reset(32'($urandom) & 32'h00FF_FFFC);
            for (int c = 0; c < 100; c++) begin
                stall_i = ($urandom_range(99) < 5);
                flush_i = ($urandom_range(99) < 3);
                flush_tgt = 32'($urandom) & 32'hFFFF_FFFC;
                step();
            end
        end
        stall_i = 1'b0;
        flush_i = 1'b0;
        chk("random_progress", 32'(n_pop > 500), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
